// File: rtl/seq_gen.sv
// Serial 1-0-1 pattern source: shifts a WIDTH-bit word out MSB first, reps+1 times back to back.
// Define SEQ_GEN_SYNC_EN to prefix every repetition with a 1,0,1 sync preamble.
module seq_gen #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [REP_W-1:0] reps_i,
    output logic             ready_o,
    output logic             out_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST    = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_PENULT  = BW'(WIDTH - 2);

`ifdef SEQ_GEN_SYNC_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd2} state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] word_q;
    logic [REP_W-1:0] rep_q;
    logic [BW-1:0]    bit_q;
    logic             out_q;
    logic             busy_q;
    logic             done_q;
`ifdef SEQ_GEN_SYNC_EN
    logic [1:0]       sync_q;
`endif

    logic [WIDTH-1:0] shift_d;
    logic [REP_W-1:0] rep_d;
`ifndef SEQ_GEN_SYNC_EN
    logic [WIDTH-1:0] start_shift_d;
    logic [WIDTH-1:0] reload_shift_d;
`endif

    // Shift/decrement helpers for the sequencer below.
    always_comb begin
        shift_d        = {shift_q[WIDTH-2:0], 1'b0};
        rep_d          = rep_q - REP_W'(1);
`ifndef SEQ_GEN_SYNC_EN
        start_shift_d  = {data_i[WIDTH-2:0], 1'b0};
        reload_shift_d = {word_q[WIDTH-2:0], 1'b0};
`endif
    end

    // Frame sequencer; out_q always holds the bit currently on the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            word_q  <= '0;
            rep_q   <= '0;
            bit_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_GEN_SYNC_EN
            sync_q  <= 2'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (load_i) begin
                        word_q <= data_i;
                        rep_q  <= reps_i;
                        bit_q  <= '0;
                        busy_q <= 1'b1;
`ifdef SEQ_GEN_SYNC_EN
                        state_q <= SYNC;
                        sync_q  <= 2'd0;
                        out_q   <= 1'b1;
                        shift_q <= data_i;
`else
                        state_q <= DATA;
                        out_q   <= data_i[WIDTH-1];
                        shift_q <= start_shift_d;
`endif
                    end else begin
                        out_q  <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
`ifdef SEQ_GEN_SYNC_EN
                SYNC: begin
                    if (sync_q == 2'd2) begin
                        state_q <= DATA;
                        out_q   <= shift_q[WIDTH-1];
                        shift_q <= shift_d;
                        bit_q   <= '0;
                    end else begin
                        sync_q <= sync_q + 2'd1;
                        out_q  <= (sync_q == 2'd1);
                    end
                end
`endif
                DATA: begin
                    if (bit_q == BIT_LAST) begin
                        done_q <= 1'b0;
                        if (rep_q != '0) begin
                            // Next repetition starts on the very next cycle, no gap.
                            rep_q <= rep_d;
                            bit_q <= '0;
`ifdef SEQ_GEN_SYNC_EN
                            state_q <= SYNC;
                            sync_q  <= 2'd0;
                            out_q   <= 1'b1;
                            shift_q <= word_q;
`else
                            out_q   <= word_q[WIDTH-1];
                            shift_q <= reload_shift_d;
`endif
                        end else begin
                            state_q <= IDLE;
                            out_q   <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        out_q   <= shift_q[WIDTH-1];
                        shift_q <= shift_d;
                        bit_q   <= bit_q + BW'(1);
                        done_q  <= (bit_q == BIT_PENULT) && (rep_q == '0);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    out_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = (state_q == IDLE);
    assign out_o   = out_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed self-checking bench for seq_gen (WIDTH=8, REP_W=4); expectations follow SEQ_GEN_SYNC_EN.
module tb_seq_gen;

`ifdef SEQ_GEN_SYNC_EN
    localparam int SOFF = 3;
`else
    localparam int SOFF = 0;
`endif
    localparam int L = 8 + SOFF;

    logic       clk;
    logic       rst;
    logic       load_s;
    logic [7:0] data_s;
    logic [3:0] reps_s;
    logic       ready_s;
    logic       out_s;
    logic       busy_s;
    logic       done_s;

    int n_checks = 0;
    int n_fail   = 0;

    seq_gen #(.WIDTH(8), .REP_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_s),
        .data_i  (data_s),
        .reps_i  (reps_s),
        .ready_o (ready_s),
        .out_o   (out_s),
        .busy_o  (busy_s),
        .done_o  (done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_s = 1'b0; data_s = 8'h00; reps_s = 4'h0;
        tick(); tick();
        rst = 1'b0;
        n_checks++;
        if ({out_s, busy_s, done_s, ready_s} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_init: out/busy/done/ready=%b expected 0001", {out_s, busy_s, done_s, ready_s});
        end
        // Mid-frame reset: start a frame, then hold rst for 2 cycles.
        load_s = 1'b1; data_s = 8'hFF; reps_s = 4'h3;
        tick();
        load_s = 1'b0;
        tick(); tick();
        n_checks++;
        if (busy_s !== 1'b1 || out_s !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prefr: busy=%b out=%b expected 1 1", busy_s, out_s);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({out_s, busy_s, done_s, ready_s} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_mid: out/busy/done/ready=%b expected 0001", {out_s, busy_s, done_s, ready_s});
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({out_s, busy_s, done_s, ready_s} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_after: out/busy/done/ready=%b expected 0001", {out_s, busy_s, done_s, ready_s});
        end
    endtask

    // Send one frame and check every bit; glitch_at >= 0 pulses load with 8'hFF at that bit.
    task automatic test_frame(input logic [7:0] d, input logic [3:0] r, input int glitch_at, input string nm);
        int   total;
        int   pos;
        logic exp_bit;
        total = (int'(r) + 1) * L;
        load_s = 1'b1; data_s = d; reps_s = r;
        tick();
        load_s = 1'b0; data_s = ~d; reps_s = ~r;
        for (int k = 0; k < total; k++) begin
            pos = k % L;
            if (pos < SOFF) exp_bit = (pos != 1);
            else            exp_bit = d[7 - (pos - SOFF)];
            n_checks++;
            if (out_s !== exp_bit || busy_s !== 1'b1 || ready_s !== 1'b0 || done_s !== (k == total - 1)) begin
                n_fail++;
                $display("FAIL %s bit %0d: out=%b busy=%b ready=%b done=%b expected out=%b busy=1 ready=0 done=%b",
                         nm, k, out_s, busy_s, ready_s, done_s, exp_bit, (k == total - 1));
            end
            if (k == glitch_at) begin
                load_s = 1'b1; data_s = 8'hFF; reps_s = 4'h0;
            end else begin
                load_s = 1'b0;
            end
            tick();
        end
        load_s = 1'b0;
        n_checks++;
        if ({out_s, busy_s, done_s, ready_s} !== 4'b0001) begin
            n_fail++;
            $display("FAIL %s end: out/busy/done/ready=%b expected 0001", nm, {out_s, busy_s, done_s, ready_s});
        end
        tick();
        n_checks++;
        if ({out_s, busy_s, ready_s} !== 3'b001) begin
            n_fail++;
            $display("FAIL %s idle: out/busy/ready=%b expected 001", nm, {out_s, busy_s, ready_s});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic       exp_bit;
        int         pos;
        d = 8'hC3;
        load_s = 1'b1; data_s = d; reps_s = 4'h0;
        tick();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < L; k++) begin
                pos = k;
                if (pos < SOFF) exp_bit = (pos != 1);
                else            exp_bit = d[7 - (pos - SOFF)];
                n_checks++;
                if (out_s !== exp_bit || busy_s !== 1'b1 || done_s !== (k == L - 1)) begin
                    n_fail++;
                    $display("FAIL b2b f%0d bit %0d: out=%b busy=%b done=%b expected out=%b busy=1 done=%b",
                             f, k, out_s, busy_s, done_s, exp_bit, (k == L - 1));
                end
                tick();
            end
            n_checks++;
            if ({out_s, busy_s, ready_s} !== 3'b001) begin
                n_fail++;
                $display("FAIL b2b gap%0d: out/busy/ready=%b expected 001", f, {out_s, busy_s, ready_s});
            end
            if (f == 1) load_s = 1'b0;
            tick();
        end
        n_checks++;
        if ({out_s, busy_s, ready_s} !== 3'b001) begin
            n_fail++;
            $display("FAIL b2b stop: out/busy/ready=%b expected 001", {out_s, busy_s, ready_s});
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5, 4'h0, -1, "a5_single");
        test_frame(8'h81, 4'h2, -1, "81_rep2");
        test_frame(8'h00, 4'h1, -1, "00_rep1");
        test_frame(8'hA5, 4'h0, 3,  "load_busy");
        test_back_to_back();
        test_frame(8'h01, 4'hF, -1, "01_repmax");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
